// File: rtl/nand3_gate.sv
`timescale 1ns/10ps
`default_nettype none
// ============================================================================
// Module   : nand3_gate
// Purpose  : Three-input NAND cell with an optional propagation delay.
//            This is the only gate primitive in the SR latch. Tie an
//            unused input to 1 to get a two-input NAND.
// Ports    : y          - output, ~(a & b & c)
//            a, b, c    - inputs
// Params   : GATE_DELAY - propagation delay in ns. 0 selects a plain
//                         zero-delay continuous assignment.
// Revision : 1.0 - initial release
// ============================================================================
module nand3_gate #(
    parameter int GATE_DELAY = 0
) (
    output logic y,
    input  logic a,
    input  logic b,
    input  logic c
);

    // A zero delay uses a plain assignment. The cross-coupled loop then
    // settles inside one evaluation and does not bounce through time-zero
    // scheduling events.
    generate
        if (GATE_DELAY == 0) begin : g_zero_delay
            assign y = ~(a & b & c);
        end else begin : g_timed
            assign #(GATE_DELAY) y = ~(a & b & c);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/sr_latch.sv
`timescale 1ns/10ps
`default_nettype none
// ============================================================================
// Module   : sr_latch
// Purpose  : Clock-gated, level-sensitive SR latch built from four NANDs.
//            It has asynchronous active-low preset (nP) and reset (nR).
//            Q and Qbar come straight from the cross-coupled NAND pair and
//            are never registered.
// Ports    : Q    - output, latch state
//            Qbar - output, complementary state. It can be 1 together
//                   with Q in the forbidden (S=R=1 while C=1) and override
//                   cases.
//            S    - input, set request, sampled while C=1
//            R    - input, reset request, sampled while C=1
//            C    - input, latch enable; transparent while high
//            nP   - input, asynchronous active-low preset, forces Q=1
//            nR   - input, asynchronous active-low reset, forces Qbar=1
// Params   : GATE_DELAY - per-gate propagation delay in ns
// Revision : 1.0 - initial release
// ============================================================================
module sr_latch #(
    parameter int GATE_DELAY = 0
) (
    output logic Q,
    output logic Qbar,
    input  logic S,
    input  logic R,
    input  logic C,
    input  logic nP,
    input  logic nR
);

    // Gated set/reset, both active-low: low only while C=1 and the request is high.
    logic sg;
    logic rg;

    // Enable stage: two-input NANDs built from the three-input cell with
    // the spare input tied high.
    nand3_gate #(.GATE_DELAY(GATE_DELAY)) u_set_gate (
        .y (sg),
        .a (S),
        .b (C),
        .c (1'b1)
    );

    nand3_gate #(.GATE_DELAY(GATE_DELAY)) u_rst_gate (
        .y (rg),
        .a (R),
        .b (C),
        .c (1'b1)
    );

    // Storage stage: cross-coupled pair. Preset enters the Q gate and
    // reset enters the Qbar gate, so either one overrides the enable
    // stage. With C=0 the pair holds its state.
    nand3_gate #(.GATE_DELAY(GATE_DELAY)) u_q_gate (
        .y (Q),
        .a (nP),
        .b (sg),
        .c (Qbar)
    );

    nand3_gate #(.GATE_DELAY(GATE_DELAY)) u_qbar_gate (
        .y (Qbar),
        .a (nR),
        .b (rg),
        .c (Q)
    );

endmodule
`default_nettype wire

// File: tb/tb_sr_latch.sv
`timescale 1ns/10ps
`default_nettype none
// ============================================================================
// Module   : tb_sr_latch
// Purpose  : Self-checking bench for sr_latch. It runs directed sequences
//            and a randomized walk compared against a truth-level model,
//            then a timing check of a GATE_DELAY=1 instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sr_latch;

    // Zero-delay instance
    logic S, R, C, nP, nR;
    logic Q, Qbar;

    // One-nanosecond-per-gate instance
    logic d_S, d_R, d_C, d_nP, d_nR;
    logic d_Q, d_Qbar;

    int checks   = 0;
    int failures = 0;

    sr_latch #(.GATE_DELAY(0)) dut (
        .Q    (Q),
        .Qbar (Qbar),
        .S    (S),
        .R    (R),
        .C    (C),
        .nP   (nP),
        .nR   (nR)
    );

    sr_latch #(.GATE_DELAY(1)) dut_d (
        .Q    (d_Q),
        .Qbar (d_Qbar),
        .S    (d_S),
        .R    (d_R),
        .C    (d_C),
        .nP   (d_nP),
        .nR   (d_nR)
    );

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_pair(input string tag, input logic eq, input logic eqb);
        check({tag, ".Q"},    Q,    eq);
        check({tag, ".Qbar"}, Qbar, eqb);
    endtask

    // Apply one vector to the zero-delay instance. C/S/R are written
    // before the overrides, and all five change in one time step.
    task automatic apply(input logic c, input logic s, input logic r,
                         input logic np, input logic nr);
        C = c; S = s; R = r; nP = np; nR = nr;
    endtask

    // Reference model in terms of the latch's observable rules:
    //   Q is forced high by preset or by an enabled set.
    //   Qbar is forced high by reset or by an enabled reset request.
    //   A forced side wins. The unforced side is the complement.
    //   With nothing forced, the previous state is held.
    logic m_q, m_qb;

    task automatic model_step(input logic c, input logic s, input logic r,
                              input logic np, input logic nr);
        logic fq, fqb;
        fq  = !np || (c && s);
        fqb = !nr || (c && r);
        if (fq && fqb) begin
            m_q = 1'b1; m_qb = 1'b1;
        end else if (fq) begin
            m_q = 1'b1; m_qb = 1'b0;
        end else if (fqb) begin
            m_q = 1'b0; m_qb = 1'b1;
        end
        // else hold m_q / m_qb
    endtask

    initial begin
        // ---------------- directed sequence ----------------
        apply(1, 1, 0, 1, 1);                   // t=0 set
        #1 check_pair("set_t0", 1'b1, 1'b0);
        #4 apply(1, 0, 0, 1, 1);                // t=5 hold
        #1 check_pair("hold_after_set", 1'b1, 1'b0);
        #4 apply(1, 0, 1, 1, 1);                // t=10 reset
        #1 check_pair("reset_t10", 1'b0, 1'b1);
        #4 apply(1, 0, 0, 1, 1);                // t=15 hold
        #1 check_pair("hold_after_reset", 1'b0, 1'b1);
        #4 apply(1, 0, 1, 1, 1);                // t=20 reset again
        #1 check_pair("reset_again", 1'b0, 1'b1);
        #4 apply(1, 0, 1, 0, 1);                // t=25 preset with R active
        #1 check_pair("preset_with_r", 1'b1, 1'b1);
        #4 apply(1, 0, 1, 1, 0);                // t=30 clear
        #1 check_pair("clear", 1'b0, 1'b1);
        #4 apply(1, 0, 1, 0, 0);                // t=35 both overrides
        #1 check_pair("both_overrides", 1'b1, 1'b1);
        // Release the overrides under a definite set so the outcome is defined
        #4 apply(1, 1, 0, 1, 1);
        #1 check_pair("release_into_set", 1'b1, 1'b0);

        // C=0 after set: S/R ignored
        #4 apply(0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) begin
            #4 apply(0, i[1], i[0], 1, 1);
            #1 check_pair($sformatf("c0_hold_set_sr%0d", i), 1'b1, 1'b0);
        end
        // Reset, then C=0 sweep
        #4 apply(1, 0, 1, 1, 1);
        #1 check_pair("reset_before_sweep", 1'b0, 1'b1);
        #4 apply(0, 0, 0, 1, 1);
        for (int i = 0; i < 4; i++) begin
            #4 apply(0, i[1], i[0], 1, 1);
            #1 check_pair($sformatf("c0_hold_rst_sr%0d", i), 1'b0, 1'b1);
        end

        // Preset pulse with C=0, Q=0
        #4 apply(0, 0, 0, 0, 1);
        #1 check_pair("np_pulse_during", 1'b1, 1'b0);
        #4 apply(0, 0, 0, 1, 1);
        #1 check_pair("np_pulse_after", 1'b1, 1'b0);
        // Reset pulse with C=0
        #4 apply(0, 0, 0, 1, 0);
        #1 check_pair("nr_pulse_during", 1'b0, 1'b1);
        #4 apply(0, 0, 0, 1, 1);
        #1 check_pair("nr_pulse_after", 1'b0, 1'b1);

        // Clear with an enabled set request: Q follows the set side
        #4 apply(1, 1, 0, 1, 0);
        #1 check_pair("clear_with_set", 1'b1, 1'b1);
        #4 apply(1, 0, 1, 1, 1);
        #1 check_pair("reset_after_clear", 1'b0, 1'b1);

        // ---------------- randomized walk ----------------
        m_q = 1'b0; m_qb = 1'b1;
        for (int i = 0; i < 80; i++) begin
            logic c, s, r, np, nr;
            c  = 1'($urandom_range(0, 1));
            s  = 1'($urandom_range(0, 1));
            r  = 1'($urandom_range(0, 1));
            np = ($urandom_range(0, 3) != 0);
            nr = ($urandom_range(0, 3) != 0);
            // Leaving the Q=Qbar=1 state into a pure hold is undefined.
            // Steer such a vector into a definite set.
            if (m_q && m_qb && np && nr && !(c && (s || r))) begin
                c = 1'b1; s = 1'b1; r = 1'b0;
            end
            if (m_q && m_qb && np && nr && c && s && r) begin
                r = 1'b0;
            end
            #4 apply(c, s, r, np, nr);
            model_step(c, s, r, np, nr);
            #1 check_pair($sformatf("rand%0d", i), m_q, m_qb);
        end

        // ---------------- gate-delay instance ----------------
        d_C = 1'b1; d_S = 1'b0; d_R = 1'b1; d_nP = 1'b1; d_nR = 1'b0;
        #10 d_nR = 1'b1;
        #10;
        check("dly_pre.Q",    d_Q,    1'b0);
        check("dly_pre.Qbar", d_Qbar, 1'b1);
        d_S = 1'b1; d_R = 1'b0;
        #1.5;
        check("dly_1p5.Q",    d_Q,    1'b0);
        #1;
        check("dly_2p5.Q",    d_Q,    1'b1);
        check("dly_2p5.Qbar", d_Qbar, 1'b1);
        #1;
        check("dly_3p5.Qbar", d_Qbar, 1'b0);
        check("dly_3p5.Q",    d_Q,    1'b1);

        #5;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
